// File: rtl/pic_pkg.sv
// pic_pkg: shared phase, ALU-op and decode types plus opcode patterns for the PIC10F200 control path
package pic_pkg;

    typedef enum logic [1:0] {Q1 = 2'd0, Q2 = 2'd1, Q3 = 2'd2, Q4 = 2'd3} q_t;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_AND   = 5'd2,
        OP_IOR   = 5'd3,
        OP_XOR   = 5'd4,
        OP_COM   = 5'd5,
        OP_INC   = 5'd6,
        OP_DEC   = 5'd7,
        OP_RLF   = 5'd8,
        OP_RRF   = 5'd9,
        OP_SWAP  = 5'd10,
        OP_PASSB = 5'd11,
        OP_PASSA = 5'd12,
        OP_CLR   = 5'd13,
        OP_BCLR  = 5'd14,
        OP_BSET  = 5'd15,
        OP_BTST  = 5'd16
    } alu_op_t;

    typedef enum logic [1:0] {SK_NONE = 2'd0, SK_Z = 2'd1, SK_NZ = 2'd2} skip_t;

    typedef struct packed {
        logic    mux_sel;
        alu_op_t alu_op;
        logic    w_wr;
        logic    f_wr;
        logic    jump;
        logic    call;
        logic    ret;
        logic    sleep;
        skip_t   skip;
    } dec_t;

    localparam logic [11:0] I_CLRW    = 12'h040;
    localparam logic [11:0] I_SLEEP   = 12'h003;
    localparam logic [6:0]  P_MOVWF   = 7'b0000001;
    localparam logic [6:0]  P_CLRF    = 7'b0000011;
    localparam logic [1:0]  P_BYTE    = 2'b00;
    localparam logic [1:0]  P_BIT     = 2'b01;
    localparam logic [3:0]  P_RETLW   = 4'h8;
    localparam logic [3:0]  P_CALL    = 4'h9;
    localparam logic [2:0]  P_GOTO    = 3'b101;
    localparam logic [1:0]  P_LIT     = 2'b11;
    localparam logic [3:0]  BS_DECFSZ = 4'hB;
    localparam logic [3:0]  BS_INCFSZ = 4'hF;

    // Byte-oriented op selector ir[9:6] to ALU operation; MOVF passes the file operand through
    function automatic alu_op_t byte_alu(input logic [3:0] sel);
        case (sel)
            4'h2:    return OP_SUB;
            4'h3:    return OP_DEC;
            4'h4:    return OP_IOR;
            4'h5:    return OP_AND;
            4'h6:    return OP_XOR;
            4'h7:    return OP_ADD;
            4'h9:    return OP_COM;
            4'hA:    return OP_INC;
            4'hB:    return OP_DEC;
            4'hC:    return OP_RRF;
            4'hD:    return OP_RLF;
            4'hE:    return OP_SWAP;
            4'hF:    return OP_INC;
            default: return OP_PASSB;
        endcase
    endfunction

endpackage

// File: rtl/pic_decode.sv
// pic_decode: combinational 12-bit instruction decode into operand select, ALU op, write targets and flow control
module pic_decode
    import pic_pkg::*;
(
    input  logic [11:0] ir,
    output dec_t        dec
);

    // Opcode classification; anything unmatched (NOP, CLRWDT, OPTION, TRIS, undefined) stays a plain NOP
    always_comb begin
        dec        = '0;
        dec.alu_op = OP_PASSB;
        dec.skip   = SK_NONE;
        if (ir[11:10] == P_BYTE && ir[9:7] != 3'b000) begin
            dec.alu_op = byte_alu(ir[9:6]);
            dec.w_wr   = ~ir[5];
            dec.f_wr   = ir[5];
            dec.skip   = (ir[9:6] == BS_DECFSZ || ir[9:6] == BS_INCFSZ) ? SK_Z : SK_NONE;
        end else if (ir[11:5] == P_MOVWF) begin
            dec.alu_op = OP_PASSA;
            dec.f_wr   = 1'b1;
        end else if (ir[11:5] == P_CLRF) begin
            dec.alu_op = OP_CLR;
            dec.f_wr   = 1'b1;
        end else if (ir == I_CLRW) begin
            dec.alu_op = OP_CLR;
            dec.w_wr   = 1'b1;
        end else if (ir[11:10] == P_BIT) begin
            dec.alu_op = ir[9] ? OP_BTST : ir[8] ? OP_BSET : OP_BCLR;
            dec.f_wr   = ~ir[9];
            dec.skip   = !ir[9] ? SK_NONE : ir[8] ? SK_NZ : SK_Z;
        end else if (ir[11:8] == P_RETLW) begin
            dec.mux_sel = 1'b1;
            dec.w_wr    = 1'b1;
            dec.ret     = 1'b1;
        end else if (ir[11:8] == P_CALL) begin
            dec.call = 1'b1;
        end else if (ir[11:9] == P_GOTO) begin
            dec.jump = 1'b1;
        end else if (ir[11:10] == P_LIT) begin
            dec.mux_sel = 1'b1;
            dec.w_wr    = 1'b1;
            dec.alu_op  = (ir[9:8] == 2'd0) ? OP_PASSB : (ir[9:8] == 2'd1) ? OP_IOR : (ir[9:8] == 2'd2) ? OP_AND : OP_XOR;
        end else begin
            dec.sleep = (ir == I_SLEEP);
        end
    end

endmodule

// File: rtl/pic_q_ctrl.sv
// pic_q_ctrl: Q1..Q4 sequencer with skip/branch flush and Q4 strobe gating; SLEEP/wake enabled by PIC_SLEEP_EN
module pic_q_ctrl
    import pic_pkg::*;
#(
    parameter int INSTR_W  = 12,
    parameter int ALU_OP_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INSTR_W-1:0]  instr,
    input  logic                alu_zero,
    input  logic                wake,
    output logic                mux_sel,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                w_we,
    output logic                f_we,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                stk_push,
    output logic                stk_pop,
    output logic [1:0]          q_phase,
    output logic                flush,
    output logic                sleeping
);

    q_t                 q, q_nxt;
    logic [INSTR_W-1:0] ir;
    logic               skip_r, wake_ev, q4, live, brk;
    dec_t               dec;

    pic_decode u_dec (
        .ir  (ir[11:0]),
        .dec (dec)
    );

    assign q4      = (q == Q4);
    assign live    = q4 & ~flush;
    assign brk     = dec.jump | dec.call | dec.ret;
    assign q_phase = q;
    assign mux_sel = dec.mux_sel;
    assign alu_op  = ALU_OP_W'(dec.alu_op);

    // Phase register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= Q1;
        else        q <= q_nxt;
    end

    // Next phase and Q4 strobes; a sleeping core parks in Q1 and a flushed cycle only advances the PC
    always_comb begin
        q_nxt    = sleeping ? Q1 : (q == Q1) ? Q2 : (q == Q2) ? Q3 : (q == Q3) ? Q4 : Q1;
        w_we     = live & dec.w_wr;
        f_we     = live & dec.f_wr;
        pc_load  = live & brk;
        stk_push = live & dec.call;
        stk_pop  = live & dec.ret;
        pc_inc   = q4 & ~(brk & ~flush);
    end

    // IR capture leaving Q1, skip decision from the Q3 zero flag, flush decided at the cycle boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir     <= '0;
            skip_r <= 1'b0;
            flush  <= 1'b1;
        end else begin
            if (q == Q1 && !sleeping) ir <= instr;
            if (q == Q3) skip_r <= (dec.skip == SK_Z) ? alu_zero : (dec.skip == SK_NZ) ? ~alu_zero : 1'b0;
            if (q4) flush <= ~flush & (skip_r | brk);
            else if (wake_ev) flush <= 1'b1;
        end
    end

`ifdef PIC_SLEEP_EN
    assign wake_ev = sleeping & wake;

    // Enter sleep on a live SLEEP at the end of Q4; leave it when wake is seen while parked in Q1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      sleeping <= 1'b0;
        else if (live && dec.sleep)      sleeping <= 1'b1;
        else if (wake_ev)                sleeping <= 1'b0;
    end
`else
    logic unused_sleep;
    assign unused_sleep = &{1'b0, wake, dec.sleep};
    assign wake_ev      = 1'b0;
    assign sleeping     = 1'b0;
`endif

endmodule

// File: doc/pic_q_ctrl.md
Name: pic_q_ctrl

Overview:
- Q-cycle sequencer and instruction decoder for the PIC10F200 core.
- Steps a 4-phase instruction cycle (Q1..Q4) and decodes the 12-bit instruction word.
- Drives the ALU operand-B 2:1 mux select, the ALU opcode, W/file write enables and PC/stack control.
- Sits between program memory and the datapath (operand mux, ALU, W register, register file, PC, stack).

Parameters:
- INSTR_W, 12, instruction word width (fixed by ISA; not re-parameterisable in practice).
- ALU_OP_W, 5, width of alu_op code.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  INSTR_W  instruction word from program memory; sampled at end of Q1.
- alu_zero  in  1  ALU zero flag for the current op; valid in Q3.
- wake  in  1  wake-up request; used only with SLEEP_EN.
- mux_sel  out  1  ALU operand-B select: 0 = register-file data, 1 = literal instr[7:0].
- alu_op  out  ALU_OP_W  ALU operation code.
- w_we  out  1  W register write strobe, Q4 only.
- f_we  out  1  register-file write strobe, Q4 only.
- pc_inc  out  1  PC increment strobe, Q4.
- pc_load  out  1  PC load strobe (GOTO/CALL/RETLW), Q4.
- stk_push  out  1  stack push (CALL), Q4.
- stk_pop  out  1  stack pop (RETLW), Q4.
- q_phase  out  2  current phase: 0 = Q1 .. 3 = Q4.
- flush  out  1  current cycle is a forced NOP.
- sleeping  out  1  core halted in SLEEP.

Behaviour:
- Reset (async, rst_n=0):
  - q_phase=Q1, ir=12'h000 (NOP), flush=1, sleeping=0.
  - All strobes 0, mux_sel=0, alu_op=PASSB.
  - After release, the first cycle executes as a flush (no writes), with pc_inc in Q4.
- Phase FSM: Q1->Q2->Q3->Q4->Q1, one state per clk. Stalls only in SLEEP.
- IR: captures instr on the edge leaving Q1. Decode is combinational from ir. mux_sel and alu_op are held stable Q2..Q4.
- Strobes: all are single-cycle pulses in Q4 only. When flush=1, w_we, f_we, pc_load, stk_push and stk_pop are forced 0; pc_inc=1.
- Byte-oriented ops (ADDWF ANDWF COMF DECF DECFSZ INCF INCFSZ IORWF MOVF RLF RRF SUBWF SWAPF XORWF):
  - mux_sel=0.
  - d=ir[5]: d=0 -> w_we, d=1 -> f_we.
- MOVWF: alu_op=PASSA, f_we.
- CLRF: alu_op=CLR, f_we.
- CLRW: alu_op=CLR, w_we.
- Bit ops:
  - BCF/BSF: mux_sel=0, alu_op=BCLR/BSET, f_we.
  - BTFSC/BTFSS: alu_op=BTST, no write.
- Literal ops (MOVLW ANDLW IORLW XORLW): mux_sel=1, w_we.
- RETLW: mux_sel=1, PASSB, w_we, stk_pop, pc_load.
- CALL: stk_push, pc_load.
- GOTO: pc_load.
- NOP, CLRWDT, OPTION, TRIS and all undefined encodings: no strobes except pc_inc.
- Skip: alu_zero is sampled in Q3. A skip is taken if:
  - DECFSZ/INCFSZ and alu_zero=1;
  - BTFSC and alu_zero=1;
  - BTFSS and alu_zero=0.
- Flush register: set on the Q4->Q1 edge if a skip was taken or a GOTO/CALL/RETLW executed (non-flushed); otherwise cleared. Every branch and taken skip therefore costs 2 cycles.
- pc_inc is not asserted together with pc_load.
- A flushed branch instruction has no effect.

Optional Feature:
- Macro PIC_SLEEP_EN.
- Defined:
  - SLEEP (12'h003) in a non-flushed cycle sets sleeping at the Q4 edge; the FSM holds in Q1 with all strobes 0.
  - When wake=1 is sampled in Q1, sleeping clears and the next cycle runs normally with flush=1.
  - Reset also clears sleeping.
- Undefined: SLEEP decodes as NOP, wake is ignored and sleeping is tied 0.

Decomposition:
- Package pic_pkg holds:
  - alu_op codes: ADD=0 SUB=1 AND=2 IOR=3 XOR=4 COM=5 INC=6 DEC=7 RLF=8 RRF=9 SWAP=10 PASSB=11 PASSA=12 CLR=13 BCLR=14 BSET=15 BTST=16;
  - q_phase encoding;
  - opcode pattern constants.
- One sub-module, pic_decode: purely combinational ir -> {mux_sel, alu_op, w_wr, f_wr, branch/call/ret, skip type}.
- The sequencer (FSM, flush, sleep, Q4 strobe gating) stays in pic_q_ctrl.

Test Plan:
- Reset: assert rst_n=0 mid-Q3 -> q_phase=0 and all strobes 0 immediately. First cycle after release: flush=1, only pc_inc in Q4.
- ADDWF 0x10, d=1 (12'h1F0): mux_sel=0, alu_op=ADD Q2..Q4; f_we=1 and w_we=0 in Q4 only; pc_inc=1.
- MOVLW 0x5A (12'hC5A): mux_sel=1, alu_op=PASSB, w_we in Q4. Next cycle flush=0.
- DECFSZ (12'h2F0) with alu_zero=1 in Q3 -> following cycle flush=1, ADDWF there produces no f_we. Repeat with alu_zero=0 -> no flush.
- GOTO 0x0A5 (12'hAA5): pc_load=1, pc_inc=0 in Q4, next cycle flushed. CALL -> stk_push+pc_load. RETLW 0x33 -> w_we, stk_pop, pc_load, mux_sel=1.
- With PIC_SLEEP_EN, SLEEP (12'h003): sleeping=1, q_phase held at 0 for 10 clocks. wake=1 -> resume with flush=1. Without the macro -> treated as NOP.
